// File: rtl/image_row_feeder_if.sv
// Memory-read and pixel-stream bundle for image_row_feeder.
// FEEDER_TLAST_EN adds the per-row m_last marker on the stream side.
interface image_row_feeder_if #(
    parameter int ADDR_W = 18
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              m_data_valid;
    logic [7:0]        m_data;
    logic              m_data_ready;
`ifdef FEEDER_TLAST_EN
    logic              m_last;

    modport master (
        output mem_rd_en, mem_addr, m_data_valid, m_data, m_last,
        input  mem_rd_data, m_data_ready
    );
    modport slave (
        input  mem_rd_en, mem_addr, m_data_valid, m_data, m_last,
        output mem_rd_data, m_data_ready
    );
`else
    modport master (
        output mem_rd_en, mem_addr, m_data_valid, m_data,
        input  mem_rd_data, m_data_ready
    );
    modport slave (
        input  mem_rd_en, mem_addr, m_data_valid, m_data,
        output mem_rd_data, m_data_ready
    );
`endif
endinterface

// File: rtl/image_row_feeder.sv
// Streams a grayscale frame from pixel memory into the filter IP: prefill rows, one row per
// interrupt credit, then zero pad rows. Optional macro FEEDER_TLAST_EN adds m_last.
module image_row_feeder #(
    parameter int IMAGE_WIDTH   = 512,
    parameter int IW_BIT_NUM    = 9,
    parameter int IMAGE_HEIGHT  = 512,
    parameter int IH_BIT_NUM    = 9,
    parameter int PREFILL_LINES = 4,
    parameter int PAD_LINES     = 2,
    parameter int ADDR_W        = 18
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    input  logic              intr_in,
    image_row_feeder_if.master bus
);
    localparam int PREFILL_ROWS = (PREFILL_LINES < IMAGE_HEIGHT) ? PREFILL_LINES : IMAGE_HEIGHT;
    localparam int RC_W   = IH_BIT_NUM + 1;
    localparam int PC_W   = $clog2(PAD_LINES + 2);
    localparam int CR_W   = $clog2(PREFILL_LINES + 2);
    localparam int LEFT_W = $clog2(PREFILL_ROWS * IMAGE_WIDTH + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_PREFILL, S_WAIT_INTR, S_LINE, S_PAD_WAIT, S_PAD_LINE, S_FINISH
    } state_t;

    state_t r_state, w_nextState;

    logic [ADDR_W-1:0] r_rdPtr;
    logic [LEFT_W-1:0] r_issueLeft;
    logic              r_inFlight, r_inFlightPad;
    logic [7:0]        r_fifoData [2];
    logic [1:0]        r_fifoCnt;
    logic [IW_BIT_NUM-1:0] r_outCol;
    logic [RC_W-1:0]   r_rowsSent;
    logic [PC_W-1:0]   r_padsSent;
    logic [CR_W-1:0]   r_credit;
    logic              r_intrPrev;

    logic       w_pop, w_push, w_issue, w_colLast, w_rowEnd, w_rise, w_padMode;
    logic       w_consume, w_startAccept, w_wrIdx;
    logic [2:0] w_occ;
    logic [1:0] w_keep;
    logic [7:0] w_pushData;
    logic [RC_W-1:0] w_rowsNext;

    assign w_pop      = (r_fifoCnt != 2'd0) & bus.m_data_ready;
    assign w_push     = r_inFlight;
    // Occupancy after this cycle's pop, so a streaming pipeline keeps issuing every cycle.
    assign w_occ      = 3'(r_fifoCnt) + 3'(r_inFlight) - 3'(w_pop);
    assign w_issue    = (r_issueLeft != '0) && (w_occ < 3'd2);
    assign w_colLast  = (r_outCol == IW_BIT_NUM'(IMAGE_WIDTH - 1));
    assign w_rowEnd   = w_pop & w_colLast;
    assign w_rise     = intr_in & ~r_intrPrev;
    assign w_padMode  = (r_state == S_PAD_LINE);
    assign w_rowsNext = r_rowsSent + RC_W'(1);
    assign w_keep     = r_fifoCnt - 2'(w_pop);
    assign w_wrIdx    = (w_keep != 2'd0);
    assign w_pushData = r_inFlightPad ? 8'h00 : bus.mem_rd_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_nextState;
    end

    always_comb begin
        w_nextState   = r_state;
        w_consume     = 1'b0;
        w_startAccept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_startAccept = 1'b1;
                    w_nextState   = S_PREFILL;
                end
            end
            S_PREFILL: begin
                if (w_rowEnd && (w_rowsNext == RC_W'(PREFILL_ROWS))) begin
                    if (PREFILL_LINES >= IMAGE_HEIGHT) w_nextState = S_PAD_WAIT;
                    else                               w_nextState = S_WAIT_INTR;
                end
            end
            S_WAIT_INTR: begin
                if (r_credit != '0) begin
                    w_consume   = 1'b1;
                    w_nextState = S_LINE;
                end
            end
            S_LINE: begin
                if (w_rowEnd) begin
                    if (w_rowsNext == RC_W'(IMAGE_HEIGHT)) w_nextState = S_PAD_WAIT;
                    else                                   w_nextState = S_WAIT_INTR;
                end
            end
            S_PAD_WAIT: begin
                if (r_padsSent == PC_W'(PAD_LINES)) begin
                    w_nextState = S_FINISH;
                end else if (r_credit != '0) begin
                    w_consume   = 1'b1;
                    w_nextState = S_PAD_LINE;
                end
            end
            S_PAD_LINE: begin
                if (w_rowEnd) w_nextState = S_PAD_WAIT;
            end
            S_FINISH: w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
    end

    // A rise coinciding with a consume cancels out; credits saturate at the prefill depth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_intrPrev <= 1'b0;
            r_credit   <= '0;
        end else begin
            r_intrPrev <= intr_in;
            if (w_startAccept) begin
                r_credit <= '0;
            end else if (r_state != S_IDLE) begin
                if (w_rise && !w_consume && (r_credit != CR_W'(PREFILL_LINES)))
                    r_credit <= r_credit + CR_W'(1);
                else if (!w_rise && w_consume)
                    r_credit <= r_credit - CR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdPtr       <= '0;
            r_issueLeft   <= '0;
            r_inFlight    <= 1'b0;
            r_inFlightPad <= 1'b0;
            r_outCol      <= '0;
            r_rowsSent    <= '0;
            r_padsSent    <= '0;
        end else begin
            r_inFlight    <= w_issue;
            r_inFlightPad <= w_padMode;
            if (w_startAccept) begin
                r_rdPtr     <= base_addr;
                r_issueLeft <= LEFT_W'(PREFILL_ROWS * IMAGE_WIDTH);
                r_outCol    <= '0;
                r_rowsSent  <= '0;
                r_padsSent  <= '0;
            end else begin
                if (w_consume)    r_issueLeft <= LEFT_W'(IMAGE_WIDTH);
                else if (w_issue) r_issueLeft <= r_issueLeft - LEFT_W'(1);
                if (w_issue && !w_padMode) r_rdPtr <= r_rdPtr + ADDR_W'(1);
                if (w_pop) r_outCol <= w_colLast ? '0 : r_outCol + IW_BIT_NUM'(1);
                if (w_rowEnd) begin
                    if (w_padMode) r_padsSent <= r_padsSent + PC_W'(1);
                    else           r_rowsSent <= w_rowsNext;
                end
            end
        end
    end

    // Two-entry FIFO: entry 0 is the stream head, entry 1 absorbs the read latency under stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fifoData[0] <= 8'h00;
            r_fifoData[1] <= 8'h00;
            r_fifoCnt     <= 2'd0;
        end else begin
            if (w_pop)  r_fifoData[0] <= r_fifoData[1];
            if (w_push) r_fifoData[w_wrIdx] <= w_pushData;
            r_fifoCnt <= r_fifoCnt + 2'(w_push) - 2'(w_pop);
        end
    end

    assign bus.m_data       = r_fifoData[0];
    assign bus.m_data_valid = (r_fifoCnt != 2'd0);
    assign bus.mem_rd_en    = w_issue & ~w_padMode;
    assign bus.mem_addr     = r_rdPtr;
    assign busy             = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign done             = (r_state == S_FINISH);
`ifdef FEEDER_TLAST_EN
    assign bus.m_last       = (r_fifoCnt != 2'd0) & w_colLast;
`endif
endmodule

// File: tb/tb_image_row_feeder.sv
// Self-checking bench for image_row_feeder on an 8x8 image whose memory returns address LSBs.
// Covers prefill, per-interrupt rows, frame end, random backpressure and reset mid-row.
module tb_image_row_feeder;
    localparam int W      = 8;
    localparam int H      = 8;
    localparam int PAD    = 2;
    localparam int ADDR_W = 18;
    localparam int TOTAL  = (H + PAD) * W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              busy, done;
    logic              intr_in;

    image_row_feeder_if #(.ADDR_W(ADDR_W)) bus();

    image_row_feeder #(
        .IMAGE_WIDTH(W), .IW_BIT_NUM(3), .IMAGE_HEIGHT(H), .IH_BIT_NUM(3),
        .PREFILL_LINES(4), .PAD_LINES(PAD), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .intr_in(intr_in), .bus(bus)
    );

    always #5 clk = ~clk;

    // Pixel memory: each location holds the low byte of its own address.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= bus.mem_addr[7:0];
    end

    int nChecks = 0;
    int nFails  = 0;
    int cyc = 0;
    int xferIdx = 0;
    int expBase = 0;
    int doneCount = 0;
    int firstXferCyc = 0;
    int lastXferCyc = 0;
    int startCyc = 0;
    bit prevHold = 1'b0;
    logic [7:0] prevData = 8'h00;
    logic prevLast = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference stream: image pixels in raster order from base, then all-zero pad rows.
    function automatic int expPixel(input int idx);
        if (idx < W * H) return (expBase + idx) & 8'hFF;
        return 0;
    endfunction

    // Stream monitor, sampling mid-cycle so values are those the next rising edge will see.
    always @(negedge clk) begin
        if (!reset_n) begin
            prevHold = 1'b0;
        end else begin
            if (prevHold) begin
                checkOutput("heldValid", int'(bus.m_data_valid), 1);
                checkOutput("heldData", int'(bus.m_data), int'(prevData));
`ifdef FEEDER_TLAST_EN
                checkOutput("heldLast", int'(bus.m_last), int'(prevLast));
`endif
            end
`ifdef FEEDER_TLAST_EN
            if (bus.m_data_valid)
                checkOutput($sformatf("last[%0d]", xferIdx), int'(bus.m_last),
                            int'((xferIdx % W) == W - 1));
            prevLast = bus.m_last;
`endif
            if (bus.m_data_valid && bus.m_data_ready) begin
                checkOutput($sformatf("pixel[%0d]", xferIdx), int'(bus.m_data), expPixel(xferIdx));
                if (xferIdx == 0) firstXferCyc = cyc;
                lastXferCyc = cyc;
                xferIdx++;
            end
            if (done) begin
                doneCount++;
                checkOutput("busyLowWithDone", int'(busy), 0);
                checkOutput("doneAfterLastXfer", xferIdx, TOTAL);
            end
            prevHold = bus.m_data_valid & ~bus.m_data_ready;
            prevData = bus.m_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic startFrame(input int base);
        base_addr = ADDR_W'(base);
        expBase   = base;
        xferIdx   = 0;
        start     = 1'b1;
        tick(1);
        startCyc  = cyc;
        start     = 1'b0;
    endtask

    task automatic applyStimulus(input int pulses, input int gap);
        for (int i = 0; i < pulses; i++) begin
            intr_in = 1'b1;
            tick(1);
            intr_in = 1'b0;
            tick(gap);
        end
    endtask

    typedef struct {
        int pulses;
        int gap;
        int settle;
        int expXfers;
        int expBusy;
        int expDone;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int budget;
        int cd;
        int doneStart;

        vecs[0] = '{pulses: 0, gap: 0, settle: 50, expXfers: 32, expBusy: 1, expDone: 0};
        vecs[1] = '{pulses: 1, gap: 1, settle: 30, expXfers: 40, expBusy: 1, expDone: 0};
        vecs[2] = '{pulses: 2, gap: 1, settle: 40, expXfers: 56, expBusy: 1, expDone: 0};
        vecs[3] = '{pulses: 1, gap: 1, settle: 30, expXfers: 64, expBusy: 1, expDone: 0};
        vecs[4] = '{pulses: 2, gap: 1, settle: 50, expXfers: 80, expBusy: 0, expDone: 1};
        vecs[5] = '{pulses: 1, gap: 1, settle: 20, expXfers: 80, expBusy: 0, expDone: 1};

        reset_n = 1'b0;
        start = 1'b0;
        intr_in = 1'b0;
        base_addr = '0;
        bus.m_data_ready = 1'b1;
        tick(3);
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstDone", int'(done), 0);
        checkOutput("rstRdEn", int'(bus.mem_rd_en), 0);
        checkOutput("rstAddr", int'(bus.mem_addr), 0);
        checkOutput("rstValid", int'(bus.m_data_valid), 0);
        checkOutput("rstData", int'(bus.m_data), 0);
        reset_n = 1'b1;
        tick(2);

        $display("[TB] frame 1: prefill, rows on interrupts, pad rows");
        startFrame(0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].pulses, vecs[i].gap);
            tick(vecs[i].settle);
            checkOutput($sformatf("phase%0d.xfers", i), xferIdx, vecs[i].expXfers);
            checkOutput($sformatf("phase%0d.busy", i), int'(busy), vecs[i].expBusy);
            checkOutput($sformatf("phase%0d.done", i), doneCount, vecs[i].expDone);
            checkOutput($sformatf("phase%0d.idleValid", i), int'(bus.m_data_valid), 0);
            if (i == 0) begin
                checkOutput("firstValidLatency", firstXferCyc - startCyc, 2);
                checkOutput("prefillBackToBack", lastXferCyc - firstXferCyc, 31);
            end
        end

        $display("[TB] frame 2: random base, random backpressure and interrupts");
        startFrame(int'($urandom_range(0, (1 << ADDR_W) - 1)));
        doneStart = doneCount;
        budget = 0;
        cd = 3;
        while (doneCount == doneStart && budget < 4000) begin
            bus.m_data_ready = 1'($urandom_range(0, 1));
            if (cd == 0) begin
                intr_in = 1'b1;
                cd = int'($urandom_range(6, 20));
            end else begin
                intr_in = 1'b0;
                cd--;
            end
            tick(1);
            budget++;
        end
        intr_in = 1'b0;
        bus.m_data_ready = 1'b1;
        tick(5);
        checkOutput("randFrameDone", doneCount - doneStart, 1);
        checkOutput("randFrameXfers", xferIdx, TOTAL);
        checkOutput("randFrameBusy", int'(busy), 0);

        $display("[TB] frame 3: reset during row 5 discards frame and credits");
        startFrame(0);
        tick(45);
        applyStimulus(1, 1);
        tick(2);
        applyStimulus(3, 1);
        budget = 0;
        while (xferIdx < 43 && budget < 200) begin
            tick(1);
            budget++;
        end
        checkOutput("reachedRow5", int'(xferIdx >= 43 && xferIdx < 48), 1);
        doneStart = doneCount;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("asyncBusy", int'(busy), 0);
        checkOutput("asyncDone", int'(done), 0);
        checkOutput("asyncRdEn", int'(bus.mem_rd_en), 0);
        checkOutput("asyncAddr", int'(bus.mem_addr), 0);
        checkOutput("asyncValid", int'(bus.m_data_valid), 0);
        checkOutput("asyncData", int'(bus.m_data), 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        startFrame(0);
        tick(60);
        checkOutput("replayXfers", xferIdx, 32);
        checkOutput("replayStalled", int'(bus.m_data_valid), 0);
        checkOutput("replayBusy", int'(busy), 1);
        checkOutput("abortNoDone", doneCount - doneStart, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
